// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, valid/ready on both sides.
// Define DIGIT_SERIAL_ADDER_OVF_EN to add the signed-overflow output OVF.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [0:WIDTH-1] SUM,
    output logic             COUT
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int DSAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N     = WIDTH / DSAFE;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DSAFE) != 0)) begin : g_bad_params
            $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic              carry_reg;
    logic              cout_reg;
    logic              alive_reg;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [WIDTH-1:0]  a_n, b_n, sum_n;
    logic [DIGIT-1:0]  a_dig [N];
    logic [DIGIT-1:0]  b_dig [N];
    logic [DIGIT-1:0]  sum_dig_reg [N];
    logic [DIGIT-1:0]  a_cur, b_cur;
    logic [DIGIT:0]    dsum;
    logic              last;
    logic              accept;

    // Ports use index 0 = MSB; internally everything is conventional [WIDTH-1:0].
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            assign a_n[gi]           = A[WIDTH-1-gi];
            assign b_n[gi]           = B[WIDTH-1-gi];
            assign SUM[WIDTH-1-gi]   = sum_n[gi];
        end
        for (gi = 0; gi < N; gi++) begin : g_digits
            assign a_dig[gi]                 = a_reg[gi*DIGIT +: DIGIT];
            assign b_dig[gi]                 = b_reg[gi*DIGIT +: DIGIT];
            assign sum_n[gi*DIGIT +: DIGIT]  = sum_dig_reg[gi];

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    sum_dig_reg[gi] <= '0;
                end else if (state_reg == ADD && cnt_reg == CW'(gi)) begin
                    sum_dig_reg[gi] <= dsum[DIGIT-1:0];
                end
            end
        end
    endgenerate

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CW'(i)) begin
                a_cur = a_dig[i];
                b_cur = b_dig[i];
            end
        end
        dsum = {1'b0, a_cur} + {1'b0, b_cur} + {{DIGIT{1'b0}}, carry_reg};
    end

    assign last = (cnt_reg == CW'(N - 1));

    always_comb begin
        state_next = state_reg;
        IN_READY   = 1'b0;
        OUT_VALID  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                // alive_reg keeps IN_READY low until one edge after reset release
                IN_READY = alive_reg;
                accept   = alive_reg && IN_VALID;
                if (accept) state_next = ADD;
            end
            ADD: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            alive_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            alive_reg <= 1'b1;
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a_n;
                b_reg     <= SUB ? ~b_n : b_n;
                carry_reg <= SUB ? 1'b1 : CIN;
                cnt_reg   <= '0;
                cout_reg  <= 1'b0;
            end else if (state_reg == ADD) begin
                carry_reg <= dsum[DIGIT];
                if (last) cout_reg <= dsum[DIGIT];
                else      cnt_reg  <= cnt_reg + CW'(1);
            end
        end
    end

    assign COUT = cout_reg;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic ovf_reg;
    logic carry_into_msb;

    // Recover the carry into the top bit from the sum bit and its two addend bits.
    assign carry_into_msb = dsum[DIGIT-1] ^ a_cur[DIGIT-1] ^ b_cur[DIGIT-1];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == ADD && last) begin
            ovf_reg <= carry_into_msb ^ dsum[DIGIT];
        end else if (state_reg == DONE && OUT_READY) begin
            ovf_reg <= 1'b0;
        end
    end

    assign OVF = ovf_reg;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder (DIGIT=4 main instance, DIGIT=1 and DIGIT=16 sweep).
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:15] a, b;
    logic        cin, sub;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, cout0;
    logic [0:15] sum0;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, cout1;
    logic [0:15] sum1;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, cout16;
    logic [0:15] sum16;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic        ovf0, ovf1, ovf16;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid0), .IN_READY(in_ready0),
        .A(a), .B(b), .CIN(cin), .SUB(sub), .OUT_VALID(out_valid0),
        .OUT_READY(out_ready0), .SUM(sum0), .COUT(cout0)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , .OVF(ovf0)
`endif
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid1), .IN_READY(in_ready1),
        .A(a), .B(b), .CIN(cin), .SUB(sub), .OUT_VALID(out_valid1),
        .OUT_READY(out_ready1), .SUM(sum1), .COUT(cout1)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , .OVF(ovf1)
`endif
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid16), .IN_READY(in_ready16),
        .A(a), .B(b), .CIN(cin), .SUB(sub), .OUT_VALID(out_valid16),
        .OUT_READY(out_ready16), .SUM(sum16), .COUT(cout16)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        , .OVF(ovf16)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on the DIGIT=4 instance; operands are scrambled right after the accept edge.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s,
                         output int lat);
        a = av; b = bv; cin = c; sub = s; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        a = ~av; b = 16'h0000; cin = ~c; sub = ~s;
        lat = 0;
        while (!out_valid0 && lat < 40) begin
            tick();
            lat++;
        end
        $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d latency=%0d", av, bv, c, s, sum0, cout0, lat);
    endtask

    task automatic consume0();
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total_cnt++; if (in_ready0 !== 1'b0)  $display("FAIL reset_in_ready got=%0d exp=0", in_ready0);  else pass_cnt++;
        total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got=%0d exp=0", out_valid0); else pass_cnt++;
        total_cnt++; if (sum0 !== 16'h0000)   $display("FAIL reset_sum got=%h exp=0000", sum0);           else pass_cnt++;
        total_cnt++; if (cout0 !== 1'b0)      $display("FAIL reset_cout got=%0d exp=0", cout0);           else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (in_ready0 !== 1'b0)  $display("FAIL release_in_ready_early got=%0d exp=0", in_ready0); else pass_cnt++;
        tick();
        total_cnt++; if (in_ready0 !== 1'b1)  $display("FAIL release_in_ready got=%0d exp=1", in_ready0); else pass_cnt++;
    endtask

    task automatic test_add();
        int lat;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        total_cnt++; if (lat !== 4)         $display("FAIL add_wrap_latency got=%0d exp=4", lat);    else pass_cnt++;
        total_cnt++; if (sum0 !== 16'h0000) $display("FAIL add_wrap_sum got=%h exp=0000", sum0);     else pass_cnt++;
        total_cnt++; if (cout0 !== 1'b1)    $display("FAIL add_wrap_cout got=%0d exp=1", cout0);     else pass_cnt++;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        total_cnt++; if (ovf0 !== 1'b0)     $display("FAIL add_wrap_ovf got=%0d exp=0", ovf0);       else pass_cnt++;
`endif
        consume0();
        do_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, lat);
        total_cnt++; if (sum0 !== 16'h1001) $display("FAIL add_cin_sum got=%h exp=1001", sum0);      else pass_cnt++;
        total_cnt++; if (cout0 !== 1'b0)    $display("FAIL add_cin_cout got=%0d exp=0", cout0);      else pass_cnt++;
        consume0();
    endtask

    task automatic test_sub();
        int lat;
        for (int c = 0; c < 2; c++) begin
            do_op(16'h1234, 16'h0234, c[0], 1'b1, lat);
            total_cnt++; if (sum0 !== 16'h1000) $display("FAIL sub_pos_sum cin=%0d got=%h exp=1000", c, sum0);  else pass_cnt++;
            total_cnt++; if (cout0 !== 1'b1)    $display("FAIL sub_pos_cout cin=%0d got=%0d exp=1", c, cout0); else pass_cnt++;
            consume0();
            do_op(16'h0001, 16'h0002, c[0], 1'b1, lat);
            total_cnt++; if (sum0 !== 16'hFFFF) $display("FAIL sub_neg_sum cin=%0d got=%h exp=ffff", c, sum0);  else pass_cnt++;
            total_cnt++; if (cout0 !== 1'b0)    $display("FAIL sub_neg_cout cin=%0d got=%0d exp=0", c, cout0); else pass_cnt++;
            consume0();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
        a = 16'hAAAA; b = 16'h5555; in_valid0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (sum0 !== 16'h3333) $display("FAIL bp_sum cyc=%0d got=%h exp=3333", i, sum0); else pass_cnt++;
            total_cnt++; if (cout0 !== 1'b0)    $display("FAIL bp_cout cyc=%0d got=%0d exp=0", i, cout0); else pass_cnt++;
            total_cnt++; if (in_ready0 !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%0d exp=0", i, in_ready0); else pass_cnt++;
            total_cnt++; if (out_valid0 !== 1'b1) $display("FAIL bp_out_valid cyc=%0d got=%0d exp=1", i, out_valid0); else pass_cnt++;
        end
        in_valid0 = 1'b0;
        consume0();
        total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL bp_release_out_valid got=%0d exp=0", out_valid0); else pass_cnt++;
        total_cnt++; if (in_ready0 !== 1'b1)  $display("FAIL bp_release_in_ready got=%0d exp=1", in_ready0);  else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++; if (sum0 !== 16'h0000)   $display("FAIL midrst_sum got=%h exp=0000", sum0);          else pass_cnt++;
        total_cnt++; if (cout0 !== 1'b0)      $display("FAIL midrst_cout got=%0d exp=0", cout0);          else pass_cnt++;
        total_cnt++; if (out_valid0 !== 1'b0) $display("FAIL midrst_out_valid got=%0d exp=0", out_valid0); else pass_cnt++;
        tick();
        total_cnt++; if (in_ready0 !== 1'b1)  $display("FAIL midrst_in_ready got=%0d exp=1", in_ready0);  else pass_cnt++;
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, lat);
        total_cnt++; if (lat !== 4)           $display("FAIL midrst_fresh_latency got=%0d exp=4", lat);   else pass_cnt++;
        total_cnt++; if (sum0 !== 16'h1010)   $display("FAIL midrst_fresh_sum got=%h exp=1010", sum0);    else pass_cnt++;
        total_cnt++; if (cout0 !== 1'b0)      $display("FAIL midrst_fresh_cout got=%0d exp=0", cout0);    else pass_cnt++;
        consume0();
    endtask

    task automatic test_sweep();
        int lat1, lat16;
        a = 16'hA5A5; b = 16'h5A5B; cin = 1'b0; sub = 1'b0;
        in_valid1 = 1'b1; in_valid16 = 1'b1;
        tick();
        in_valid1 = 1'b0; in_valid16 = 1'b0;
        a = 16'h0000; b = 16'h0000;
        lat1 = 0; lat16 = 0;
        while (!out_valid16 && lat16 < 40) begin tick(); lat16++; end
        $display("op digit=16 a=a5a5 b=5a5b -> sum=%h cout=%0d latency=%0d", sum16, cout16, lat16);
        total_cnt++; if (lat16 !== 1)          $display("FAIL d16_latency got=%0d exp=1", lat16);   else pass_cnt++;
        total_cnt++; if (sum16 !== 16'h0000)   $display("FAIL d16_sum got=%h exp=0000", sum16);    else pass_cnt++;
        total_cnt++; if (cout16 !== 1'b1)      $display("FAIL d16_cout got=%0d exp=1", cout16);    else pass_cnt++;
        lat1 = lat16;
        while (!out_valid1 && lat1 < 40) begin tick(); lat1++; end
        $display("op digit=1 a=a5a5 b=5a5b -> sum=%h cout=%0d latency=%0d", sum1, cout1, lat1);
        total_cnt++; if (lat1 !== 16)          $display("FAIL d1_latency got=%0d exp=16", lat1);    else pass_cnt++;
        total_cnt++; if (sum1 !== 16'h0000)    $display("FAIL d1_sum got=%h exp=0000", sum1);      else pass_cnt++;
        total_cnt++; if (cout1 !== 1'b1)       $display("FAIL d1_cout got=%0d exp=1", cout1);      else pass_cnt++;
        out_ready1 = 1'b1; out_ready16 = 1'b1;
        tick();
        out_ready1 = 1'b0; out_ready16 = 1'b0;
    endtask

    task automatic test_ovf();
        int lat;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        total_cnt++; if (sum0 !== 16'h8000) $display("FAIL ovf_add_sum got=%h exp=8000", sum0);  else pass_cnt++;
        total_cnt++; if (cout0 !== 1'b0)    $display("FAIL ovf_add_cout got=%0d exp=0", cout0);  else pass_cnt++;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        total_cnt++; if (ovf0 !== 1'b1)     $display("FAIL ovf_add_flag got=%0d exp=1", ovf0);   else pass_cnt++;
`endif
        consume0();
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        total_cnt++; if (ovf0 !== 1'b0)     $display("FAIL ovf_idle_flag got=%0d exp=0", ovf0);  else pass_cnt++;
`endif
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        total_cnt++; if (sum0 !== 16'h7FFF) $display("FAIL ovf_sub_sum got=%h exp=7fff", sum0);  else pass_cnt++;
        total_cnt++; if (cout0 !== 1'b1)    $display("FAIL ovf_sub_cout got=%0d exp=1", cout0);  else pass_cnt++;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        total_cnt++; if (ovf0 !== 1'b1)     $display("FAIL ovf_sub_flag got=%0d exp=1", ovf0);   else pass_cnt++;
`endif
        consume0();
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid16 = 1'b0;
        out_ready0 = 1'b0; out_ready1 = 1'b0; out_ready16 = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_ovf();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle successor to the fixed 4-bit ripple carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, least-significant digit first, and holds the carry in a register between digits.
- Valid/ready handshake on both sides, so it drops into datapaths that trade latency for area.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  synchronous active-low reset.
- IN_VALID  input  1  operands present.
- IN_READY  output  1  block can accept operands.
- A  input  [0:WIDTH-1]  operand A; index 0 is MSB, index WIDTH-1 is LSB.
- B  input  [0:WIDTH-1]  operand B; same ordering.
- CIN  input  1  carry-in for add mode; ignored when SUB=1.
- SUB  input  1  0 = A+B+CIN, 1 = A+~B+1 (A-B).
- OUT_VALID  output  1  result present.
- OUT_READY  input  1  consumer accepts result.
- SUM  output  [0:WIDTH-1]  result; index 0 is MSB.
- COUT  output  1  carry-out of the MSB; in SUB mode 1 = no borrow.

Behaviour:
- Bit ordering is fixed: [0:WIDTH-1] on all vectors, index 0 = MSB. Digit 0 = bits [WIDTH-DIGIT:WIDTH-1] (LSBs); digit N-1 = bits [0:DIGIT-1]. N = WIDTH/DIGIT.
- Elaboration check: WIDTH % DIGIT != 0, or DIGIT < 1, triggers a fatal error.
- Reset, sampled on CLK while RST_N=0:
  - FSM goes to IDLE; digit counter clears.
  - IN_READY=0, OUT_VALID=0, SUM=0, COUT=0; carry register clears.
  - IN_READY rises on the first cycle after RST_N returns high.
- FSM states IDLE, ADD, DONE:
  - IDLE: IN_READY=1, OUT_VALID=0. When IN_VALID=1 at a rising edge, the block:
    - captures A;
    - captures B, inverted if SUB=1;
    - loads the carry register with CIN, or 1 if SUB=1;
    - clears the counter and moves to ADD.
  - ADD: IN_READY=0. Each edge adds digit[count] of A and B plus the carry register, writes DIGIT result bits into SUM, updates the carry register and increments the counter. After the edge that processes digit N-1, COUT takes the final carry and the FSM moves to DONE.
  - DONE: OUT_VALID=1; SUM and COUT are held stable. When OUT_READY=1 at an edge, the FSM moves to IDLE and OUT_VALID drops.
- Latency:
  - Accept at edge k; OUT_VALID=1 in the cycle after edge k+N. DIGIT=WIDTH gives N=1.
  - Minimum issue interval is N+2 cycles. There is no overlap: the next operands are not accepted in the cycle OUT_VALID drops.
- Boundary rules:
  - Operands are sampled only on the accept edge; later changes on A, B, CIN or SUB have no effect.
  - IN_VALID is ignored outside IDLE.
  - OUT_READY is ignored outside DONE.
  - Overflow wraps modulo 2^WIDTH; the carry beyond the MSB appears only on COUT.
  - SUM may show partial digits during ADD. Consumers use it only while OUT_VALID=1.
  - Reset in ADD or DONE aborts the operation and discards the result; the reset values above apply.
  - The counter width is clog2(N), minimum 1 bit; the counter never wraps past N-1.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_OVF_EN
- Defined:
  - Adds output port OVF, 1 bit, signed two's-complement overflow: carry into MSB XOR carry out of MSB.
  - Valid with OUT_VALID; held in DONE.
  - Reset value 0; value during IDLE and ADD is 0.
- Undefined: port OVF and its logic do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=16, DIGIT=4: A=16'hFFFF, B=16'h0001, CIN=0, SUB=0 -> OUT_VALID exactly 4 cycles after the accept edge; SUM=16'h0000, COUT=1.
- SUB=1, A=16'h1234, B=16'h0234 -> SUM=16'h1000, COUT=1. SUB=1, A=16'h0001, B=16'h0002 -> SUM=16'hFFFF, COUT=0. In both cases CIN toggled has no effect.
- Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID -> SUM/COUT constant, IN_READY=0, new IN_VALID ignored. Raise OUT_READY -> IDLE the next cycle with IN_READY=1.
- Reset mid-op: drive RST_N=0 for 1 cycle at the 2nd ADD cycle -> the next cycle shows SUM=0, COUT=0, OUT_VALID=0; IN_READY=1 one cycle after release; a fresh operation then completes correctly.
- Parameter sweep: DIGIT=1 (16-cycle latency) and DIGIT=16 (1-cycle latency) on A=16'hA5A5, B=16'h5A5B, CIN=0 -> SUM=16'h0000, COUT=1.
- With DIGIT_SERIAL_ADDER_OVF_EN: A=16'h7FFF, B=16'h0001, SUB=0 -> SUM=16'h8000, OVF=1, COUT=0. Without the macro, the same stimulus gives identical SUM/COUT.
